sin_pwm_dac: RTL and testbench

- Downstream consumer of the sine generator's 9-bit sample output.
- Converts each sample into a complementary pair of PWM gate signals with programmable dead-time, for an external half-bridge / RC reconstruction filter.
- Samples are captured only at PWM frame boundaries (double-buffered), so sample updates never glitch a frame in progress.

---
 rtl/sin_pwm_dac.sv | 131 +++++++++++++
 tb/tb_sin_pwm_dac.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sin_pwm_dac.sv
// Sine-sample to complementary PWM converter with programmable dead-time.
// Duty is double-buffered at frame boundaries; a stop request drains gates to zero.
module sin_pwm_dac #(
  parameter int WIDTH     = 9,
  parameter int DEAD      = 2,
  parameter bit TWOS_COMP = 1'b1
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             en,
  input  logic [WIDTH-1:0] sample_in,
  output logic             pwm_p,
  output logic             pwm_n,
  output logic             frame_strobe,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] MSB_FLIP = TWOS_COMP ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
  localparam logic [3:0]       DEAD_C   = 4'(DEAD);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_r;
  logic [WIDTH-1:0] duty_in;
  logic [3:0]       dt_cnt;
  logic [3:0]       dt_next;
  logic [3:0]       drain_cnt;
  logic             raw;
  logic             raw_q;
  logic             hist_vld;
  logic             gate_ok;

  // Two's complement to offset binary is just an MSB flip.
  assign duty_in = sample_in ^ MSB_FLIP;
  assign raw     = (cnt < duty_r);

  // hist_vld=0 marks the first RUN cycle, where earlier history counts as empty.
  always_comb begin
    // NOTE: default assignment first so no path leaves dt_next unassigned (no latch).
    dt_next = '0;
    if (hist_vld && (raw == raw_q)) begin
      dt_next = (dt_cnt == DEAD_C) ? dt_cnt : dt_cnt + 4'd1;
    end
  end

  assign gate_ok = (dt_next == DEAD_C);

  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state        <= IDLE;
      cnt          <= '0;
      duty_r       <= '0;
      dt_cnt       <= '0;
      drain_cnt    <= '0;
      raw_q        <= 1'b0;
      hist_vld     <= 1'b0;
      pwm_p        <= 1'b0;
      pwm_n        <= 1'b0;
      frame_strobe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      frame_strobe <= 1'b0;
      case (state)
        IDLE: begin
          pwm_p <= 1'b0;
          pwm_n <= 1'b0;
          cnt   <= '0;
          if (en) begin
            state        <= RUN;
            busy         <= 1'b1;
            duty_r       <= duty_in;
            frame_strobe <= 1'b1;
            hist_vld     <= 1'b0;
            dt_cnt       <= '0;
          end
        end

        RUN: begin
          raw_q    <= raw;
          hist_vld <= 1'b1;
          dt_cnt   <= dt_next;
          pwm_p    <= raw & gate_ok;
          pwm_n    <= ~raw & gate_ok;
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (en) begin
              duty_r       <= duty_in;
              frame_strobe <= 1'b1;
            end else begin
              // Gates drop immediately so DRAIN shows DEAD+1 full low cycles.
              state     <= DRAIN;
              drain_cnt <= '0;
              pwm_p     <= 1'b0;
              pwm_n     <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DRAIN: begin
          pwm_p <= 1'b0;
          pwm_n <= 1'b0;
          cnt   <= '0;
          if (drain_cnt == DEAD_C) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          pwm_p <= 1'b0;
          pwm_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sin_pwm_dac.sv
// Scoreboard bench for sin_pwm_dac: a frame-level model predicts every output cycle,
// a monitor compares the DUT against the queued predictions one cycle at a time.
module tb_sin_pwm_dac;

  localparam int WIDTH = 9;
  localparam int DEAD  = 2;
  localparam int FRAME = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             resetb = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] sample_in = '0;
  logic             pwm_p;
  logic             pwm_n;
  logic             frame_strobe;
  logic             busy;

  always #5 clk = ~clk;

  sin_pwm_dac #(
    .WIDTH     (WIDTH),
    .DEAD      (DEAD),
    .TWOS_COMP (1'b1)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .en           (en),
    .sample_in    (sample_in),
    .pwm_p        (pwm_p),
    .pwm_n        (pwm_n),
    .frame_strobe (frame_strobe),
    .busy         (busy)
  );

  // Expected {pwm_p, pwm_n, frame_strobe, busy} after one clock edge.
  typedef struct {
    logic [3:0] v;
    string      tag;
  } sb_item_t;

  sb_item_t         sb[$];
  logic [WIDTH-1:0] plan_s[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               run_id = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Duty is the signed sample shifted up by half scale.
  function automatic int model_duty(input logic [WIDTH-1:0] s);
    int v;
    v = int'($signed(s));
    return v + FRAME / 2;
  endfunction

  task automatic push_exp(input logic p, input logic n, input logic st, input logic b,
                          input string tag);
    sb_item_t it;
    it.v   = {p, n, st, b};
    it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic idle_cycles(input int num);
    for (int k = 0; k < num; k++) begin
      @(negedge clk);
      en        = 1'b0;
      sample_in = WIDTH'($urandom);
      push_exp(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("idle_r%0d_%0d", run_id, k));
    end
  endtask

  // One run: frames use plan_s in order, then a stop. abort_at >= 0 hits reset mid-run.
  task automatic do_run(input int abort_at);
    int nf;
    int len;
    bit raw[];
    bit gp[];
    bit gn[];
    nf  = plan_s.size();
    len = nf * FRAME;
    raw = new[len];
    gp  = new[len];
    gn  = new[len];
    for (int i = 0; i < len; i++)
      raw[i] = ((i % FRAME) < model_duty(plan_s[i / FRAME]));
    // A gate is on after cycle i when raw held one level over cycles i-DEAD..i inside the run.
    for (int i = 0; i < len; i++) begin
      gp[i] = (i >= DEAD);
      gn[i] = (i >= DEAD);
      for (int k = i - DEAD; k <= i; k++) begin
        if (k >= 0) begin
          if (raw[k] != 1'b1) gp[i] = 1'b0;
          if (raw[k] != 1'b0) gn[i] = 1'b0;
        end
      end
    end
    for (int j = 0; j <= len + DEAD + 1; j++) begin
      logic p, n, st, b;
      @(negedge clk);
      if (j == abort_at) begin
        resetb = 1'b1;
        en     = 1'b0;
        #1;
        check("async_rst_pwm_p", int'(pwm_p), 0);
        check("async_rst_pwm_n", int'(pwm_n), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_strobe", int'(frame_strobe), 0);
        return;
      end
      if (j == 0 || (j < len && (j % FRAME) == 0)) begin
        en        = 1'b1;
        sample_in = plan_s[j / FRAME];
      end else if (j == len) begin
        en        = 1'b0;
        sample_in = WIDTH'($urandom);
      end else begin
        en        = 1'($urandom_range(0, 1));
        sample_in = WIDTH'($urandom);
      end
      b  = (j <= len + DEAD);
      st = (j < len) && ((j % FRAME) == 0);
      p  = 1'b0;
      n  = 1'b0;
      if (j >= 1 && j < len) begin
        p = gp[j-1];
        n = gn[j-1];
      end
      push_exp(p, n, st, b, $sformatf("run%0d_j%0d", run_id, j));
    end
    run_id++;
  endtask

  // Monitor: one prediction per clock edge; with nothing queued the block must be quiet.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        sb_item_t it;
        it = sb.pop_front();
        check(it.tag, int'({pwm_p, pwm_n, frame_strobe, busy}), int'(it.v));
      end else begin
        check("quiet_outputs", int'({pwm_p, pwm_n, frame_strobe, busy}), 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1 resetb = 1'b1;
    #1;
    check("reset_pwm_p", int'(pwm_p), 0);
    check("reset_pwm_n", int'(pwm_n), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_strobe", int'(frame_strobe), 0);
    repeat (2) @(negedge clk);
    resetb = 1'b0;
    idle_cycles(4);

    // Full-scale positive sample keeps pwm_p high at cnt=300, where reset strikes.
    plan_s = '{9'h0FF};
    do_run(301);
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b0;
    idle_cycles(6);
    run_id++;

    plan_s = '{9'h000, 9'h000};
    do_run(-1);
    idle_cycles(2);

    plan_s = '{9'h100, 9'h100};
    do_run(-1);

    plan_s = '{9'h0FF, 9'h0FF};
    do_run(-1);
    idle_cycles(1);

    plan_s = '{9'h000, 9'h080};
    do_run(-1);
    idle_cycles(3);

    for (int r = 0; r < 4; r++) begin
      int nf;
      nf = $urandom_range(1, 3);
      plan_s.delete();
      for (int f = 0; f < nf; f++) plan_s.push_back(WIDTH'($urandom));
      do_run(-1);
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(4);
    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
